// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame controller.
//   state_t        : frame controller FSM states
//   PAR_W_DEFAULT  : default data word width
//   PAR_LW_DEFAULT : default frame-length field width
package parity_pkg;

    localparam int PAR_W_DEFAULT  = 8;
    localparam int PAR_LW_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_xor_reduce.sv
// Combinational per-word parity: XOR of all bits of one data word.
//   i_word : W-bit data word
//   o_par  : 1 when the word holds an odd number of ones
module word_xor_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_word,
    output logic         o_par
);

    assign o_par = ^i_word;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame parity controller. Accepts a frame of len words on a valid/ready
// stream, accumulates the parity of every bit in the frame and reports the
// parity bit (odd or even mode) plus an optional mismatch flag.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   start     : begin a frame (honoured only in IDLE)
//   len       : frame length in words, sampled with start (0 = empty frame)
//   odd       : 1 = odd parity, 0 = even parity, sampled with start
//   chk       : enable comparison against exp_par, sampled with start
//   exp_par   : expected frame parity, sampled with start
//   s_data    : stream data word
//   s_valid   : stream data valid
//   s_ready   : controller accepts a word this cycle (RUN only)
//   busy      : frame in progress (RUN or DONE)
//   done_tick : one-cycle pulse at frame completion
//   par       : frame parity bit, held until the next accepted start
//   err       : parity mismatch flag, held until the next accepted start
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int W  = PAR_W_DEFAULT,
    parameter int LW = PAR_LW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          odd,
    input  logic          chk,
    input  logic          exp_par,
    input  logic [W-1:0]  s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          busy,
    output logic          done_tick,
    output logic          par,
    output logic          err
);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_acc;
    logic [LW-1:0] r_cnt;
    logic          r_odd;
    logic          r_chk;
    logic          r_exp;
    logic          r_par;
    logic          r_err;

    logic          w_word_par;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_final_par;

    word_xor_reduce #(.W(W)) u_word_xor (
        .i_word (s_data),
        .o_par  (w_word_par)
    );

    assign w_beat      = s_valid && (r_state == ST_RUN);
    assign w_last_beat = w_beat && (r_cnt == LW'(1));
    // Parity of the completed frame, including the word of the final beat,
    // so par/err are already registered when done_tick is high.
    assign w_final_par = r_acc ^ w_word_par ^ r_odd;

    assign par = r_par;
    assign err = r_err;

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        busy         = 1'b0;
        done_tick    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_last_beat) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done_tick    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_odd   <= 1'b0;
            r_chk   <= 1'b0;
            r_exp   <= 1'b0;
            r_par   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_odd <= odd;
                        r_chk <= chk;
                        r_exp <= exp_par;
                        r_acc <= 1'b0;
                        r_cnt <= len;
                        if (len == '0) begin
                            // Empty frame: parity of zero words is just the mode bit.
                            r_par <= odd;
                            r_err <= chk & (odd != exp_par);
                        end else begin
                            r_par <= 1'b0;
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        r_acc <= r_acc ^ w_word_par;
                        r_cnt <= r_cnt - LW'(1);
                        if (w_last_beat) begin
                            r_par <= w_final_par;
                            r_err <= r_chk & (w_final_par != r_exp);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          odd;
    logic          chk;
    logic          exp_par;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          busy;
    logic          done_tick;
    logic          par;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;
    int beats = 0;
    int dones = 0;

    logic [W-1:0] f_words [16];

    typedef struct packed {
        logic [3:0]      ln;
        logic            o;
        logic            c;
        logic            e;
        logic [3:0][7:0] w;
        logic [1:0]      stall;
        logic            noisy;
        logic            dstart;
        logic            x_par;
        logic            x_err;
    } vec_t;

    vec_t tbl [8];

    parity_frame_ctrl #(.W(W), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .odd       (odd),
        .chk       (chk),
        .exp_par   (exp_par),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .busy      (busy),
        .done_tick (done_tick),
        .par       (par),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Advance one clock; handshakes and done pulses are tallied from the
    // values presented before the edge.
    task automatic step();
        if (!reset && s_valid && s_ready) beats++;
        if (!reset && done_tick) dones++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: parity of all bits in the frame, flipped for odd mode.
    function automatic logic model_par(input int ln, input logic o);
        int ones = 0;
        for (int i = 0; i < ln; i++) ones += $countones(f_words[i]);
        return ((ones % 2) == 1) ^ o;
    endfunction

    function automatic vec_t mk(input logic [3:0] l, input logic o, input logic c, input logic e,
                                input logic [31:0] w, input logic [1:0] st, input logic nz,
                                input logic ds, input logic xp, input logic xe);
        vec_t v;
        v.ln = l; v.o = o; v.c = c; v.e = e; v.w = w; v.stall = st;
        v.noisy = nz; v.dstart = ds; v.x_par = xp; v.x_err = xe;
        return v;
    endfunction

    task automatic do_frame(input int ln, input logic o, input logic c, input logic e,
                            input int stall, input bit rnd, input bit noisy, input bit dstart,
                            input logic xp, input logic xe, input string tag);
        int b0;
        int d0;
        int k;
        b0 = beats;
        d0 = dones;
        check({tag, " idle busy"}, busy, 0);
        start = 1'b1; len = LW'(ln); odd = o; chk = c; exp_par = e; s_valid = 1'b0;
        step();
        start = 1'b0;
        if (ln != 0) begin
            check({tag, " run ready"}, s_ready, 1);
            check({tag, " start clears par/err"}, {par, err}, 0);
        end
        for (int i = 0; i < ln; i++) begin
            k = rnd ? int'($urandom_range(stall, 0)) : ((i == 0) ? 0 : stall);
            repeat (k) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                if (noisy) begin start = 1'($urandom); len = LW'($urandom); end
                step();
            end
            s_valid = 1'b1;
            s_data  = f_words[i];
            if (noisy) begin start = 1'($urandom); len = LW'($urandom); end
            step();
        end
        // Offer a surplus word while the frame completes; it must not be taken.
        start   = dstart;
        len     = LW'(2);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        check({tag, " done_tick"}, done_tick, 1);
        check({tag, " done ready"}, s_ready, 0);
        check({tag, " done par"}, par, xp);
        check({tag, " done err"}, err, xe);
        step();
        start   = 1'b0;
        s_valid = 1'b0;
        check({tag, " post done_tick"}, done_tick, 0);
        check({tag, " post busy"}, busy, 0);
        check({tag, " held par/err"}, {par, err}, {xp, xe});
        check({tag, " beats"}, beats - b0, ln);
        check({tag, " done count"}, dones - d0, 1);
        if (dstart) begin
            step();
            check({tag, " start at IDLE entry ignored"}, busy, 0);
        end
    endtask

    initial begin
        int   ln;
        logic o, c, e, xp, xe;

        reset = 1'b1; start = 1'b0; len = '0; odd = 1'b0; chk = 1'b0;
        exp_par = 1'b0; s_data = '0; s_valid = 1'b0;

        // Six ones in total -> even-mode parity bit is 0.
        tbl[0] = mk(4'd3, 1'b0, 1'b0, 1'b0, {8'h00, 8'h07, 8'h03, 8'h01}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(4'd2, 1'b1, 1'b0, 1'b0, {8'h00, 8'h00, 8'h0F, 8'hFF}, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[2] = mk(4'd1, 1'b0, 1'b1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h80}, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[3] = mk(4'd1, 1'b0, 1'b1, 1'b1, {8'h00, 8'h00, 8'h00, 8'h80}, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(4'd0, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[6] = mk(4'd4, 1'b1, 1'b1, 1'b1, {8'h08, 8'h04, 8'h02, 8'h01}, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[7] = mk(4'd3, 1'b0, 1'b1, 1'b1, {8'h00, 8'h70, 8'h30, 8'h10}, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        step();
        step();
        check("reset s_ready", s_ready, 0);
        check("reset busy", busy, 0);
        check("reset done_tick", done_tick, 0);
        check("reset par", par, 0);
        check("reset err", err, 0);
        reset = 1'b0;
        step();

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) f_words[i] = tbl[t].w[i];
            do_frame(int'(tbl[t].ln), tbl[t].o, tbl[t].c, tbl[t].e, int'(tbl[t].stall), 1'b0,
                     tbl[t].noisy, tbl[t].dstart, tbl[t].x_par, tbl[t].x_err,
                     $sformatf("tbl%0d", t));
        end

        // Abort a len=4 frame after two beats.
        begin
            int d0;
            d0 = dones;
            start = 1'b1; len = 4'd4; odd = 1'b1; chk = 1'b1; exp_par = 1'b0;
            step();
            start = 1'b0;
            s_valid = 1'b1; s_data = 8'h07; step();
            s_data = 8'h01; step();
            s_valid = 1'b0; reset = 1'b1; step();
            reset = 1'b0;
            check("abort s_ready", s_ready, 0);
            check("abort busy", busy, 0);
            check("abort done_tick", done_tick, 0);
            check("abort par/err", {par, err}, 0);
            step();
            step();
            check("abort no done", dones - d0, 0);
            f_words[0] = 8'h01;
            do_frame(1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "after abort");
        end

        for (int f = 0; f < 30; f++) begin
            ln = int'($urandom_range(15, 0));
            for (int i = 0; i < ln; i++) f_words[i] = W'($urandom);
            o  = 1'($urandom);
            c  = 1'($urandom);
            e  = 1'($urandom);
            xp = model_par(ln, o);
            xe = c && (xp != e);
            do_frame(ln, o, c, e, 3, 1'b1, (f % 2) == 1, (f % 3) == 0, xp, xe,
                     $sformatf("rnd%0d", f));
            repeat (int'($urandom_range(2, 0))) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
